// File: rtl/fib_engine_if.sv
// Handshake and result bundle between the Fibonacci engine and its controller/consumer.
interface fib_engine_if #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned N_WIDTH = 6
);
  logic               start;
  logic [N_WIDTH-1:0] n;
  logic               mode;
  logic               abort;
  logic [WIDTH-1:0]   term;
  logic               term_valid;
  logic               term_ready;
  logic [WIDTH-1:0]   result;
  logic               overflow;
  logic               busy;
  logic               done;

  // Controller/consumer side.
  modport master (
    output start, n, mode, abort, term_ready,
    input  term, term_valid, result, overflow, busy, done
  );

  // Engine side.
  modport slave (
    input  start, n, mode, abort, term_ready,
    output term, term_valid, result, overflow, busy, done
  );
endinterface

// File: rtl/fib_engine.sv
// Fibonacci engine: computes F(n) mod 2^WIDTH with a sticky overflow flag, optionally
// streaming every term F(0)..F(n) over a valid/ready handshake. Abortable at any time.
module fib_engine #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned N_WIDTH = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  fib_engine_if.slave  bus
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCheck,
    StEmit,
    StAdd,
    StFinish
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [N_WIDTH-1:0] cnt_q;
  logic               ovf_a_q, ovf_b_q;
  logic               mode_q;
  logic [WIDTH-1:0]   term_q;
  logic [WIDTH-1:0]   result_q;
  logic               overflow_q;
  logic [WIDTH:0]     sum;

  // Carry out of the add is the overflow indication for the new B term.
  assign sum = {1'b0, a_q} + {1'b0, b_q};

  // Next-state selection; abort overrides every transition outside idle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (bus.start) state_d = StLoad;
      StLoad:   state_d = StCheck;
      StCheck: begin
        if (mode_q)              state_d = StEmit;
        else if (cnt_q == '0)    state_d = StFinish;
        else                     state_d = StAdd;
      end
      StEmit: begin
        if (bus.term_ready)      state_d = (cnt_q == '0) ? StFinish : StAdd;
      end
      StAdd:    state_d = StCheck;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (state_q != StIdle && bus.abort) state_d = StIdle;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Datapath: operand latch, term recurrence and overflow tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      ovf_a_q <= 1'b0;
      ovf_b_q <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            cnt_q  <= bus.n;
            mode_q <= bus.mode;
          end
        end
        StLoad: begin
          a_q     <= '0;
          b_q     <= {{(WIDTH-1){1'b0}}, 1'b1};
          ovf_a_q <= 1'b0;
          ovf_b_q <= 1'b0;
        end
        StAdd: begin
          a_q     <= b_q;
          b_q     <= sum[WIDTH-1:0];
          ovf_a_q <= ovf_b_q;
          ovf_b_q <= ovf_b_q | sum[WIDTH];
          cnt_q   <= cnt_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Result is captured on entry to finish so it is already valid while done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else if (state_d == StFinish) begin
      result_q   <= a_q;
      overflow_q <= ovf_a_q;
    end
  end

  // Term register loaded on entry to emit; A does not change while stalled so it stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 term_q <= '0;
    else if (state_d == StEmit) term_q <= a_q;
  end

  assign bus.term       = term_q;
  assign bus.term_valid = (state_q == StEmit);
  assign bus.result     = result_q;
  assign bus.overflow   = overflow_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.done       = (state_q == StFinish);

endmodule

// File: tb/tb_fib_engine.sv
// Self-checking bench for fib_engine: vector table, hand-written corner sequences and
// randomized runs against a plain-arithmetic Fibonacci reference.
module tb_fib_engine;
  localparam int unsigned W  = 16;
  localparam int unsigned NW = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fib_engine_if #(.WIDTH(W), .N_WIDTH(NW)) bus ();

  fib_engine #(.WIDTH(W), .N_WIDTH(NW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Results of the most recent do_run call.
  int                run_edges;
  int                run_busy;
  int                run_stalls;
  int                stable_err;
  logic [W-1:0]      got_terms[$];

  typedef struct {
    int           n;
    bit           mode;
    logic [63:0]  exp_res;
    bit           exp_ovf;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // True (unbounded up to 64 bits) Fibonacci number.
  function automatic logic [63:0] fib_true(input int k);
    logic [63:0] a, b, t;
    a = 64'd0;
    b = 64'd1;
    for (int i = 0; i < k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // rdy_mode: 0 = always ready, 1 = 1-0-0 pattern, 2 = random. mid_start > 0 pulses START
  // (with n=3) at that cycle of the run, which must be ignored.
  task automatic do_run(input int nn, input bit md, input int rdy_mode, input int mid_start);
    bit           r;
    bit           prev_stall;
    logic [W-1:0] prev_term;
    logic [NW-1:0] nv;
    got_terms.delete();
    run_edges  = -1;
    run_busy   = 0;
    run_stalls = 0;
    stable_err = 0;
    prev_stall = 1'b0;
    prev_term  = '0;
    nv = nn[NW-1:0];
    @(negedge clk);
    bus.start      = 1'b1;
    bus.n          = nv;
    bus.mode       = md;
    bus.term_ready = 1'b0;
    @(posedge clk);
    for (int e = 0; e < 3000; e++) begin
      @(negedge clk);
      bus.start = (mid_start > 0 && e == mid_start);
      if (bus.start) bus.n = 6'd3;
      if (bus.busy) run_busy++;
      if (bus.term_valid) begin
        if (prev_stall && bus.term !== prev_term) stable_err++;
        case (rdy_mode)
          0:       r = 1'b1;
          1:       r = (e % 3 == 0);
          default: r = 1'($urandom_range(0, 1));
        endcase
        bus.term_ready = r;
        if (r) got_terms.push_back(bus.term);
        else   run_stalls++;
        prev_stall = !r;
        prev_term  = bus.term;
      end else begin
        bus.term_ready = 1'b0;
        prev_stall     = 1'b0;
      end
      if (bus.done) begin
        run_edges = e;
        break;
      end
      @(posedge clk);
    end
    bus.start      = 1'b0;
    bus.term_ready = 1'b0;
  endtask

  // Compare one completed run against the reference.
  task automatic check_run(input string tag, input int nn, input bit md);
    logic [63:0] f;
    int          exp_edges;
    f = fib_true(nn);
    exp_edges = 2 * nn + 2 + (md ? (nn + 1 + run_stalls) : 0);
    check({tag, "_latency"}, run_edges, exp_edges);
    check({tag, "_result"}, bus.result, f & 64'hFFFF);
    check({tag, "_ovf"}, bus.overflow, (f > 64'd65535) ? 64'd1 : 64'd0);
    if (md) begin
      check({tag, "_nterms"}, got_terms.size(), nn + 1);
      check({tag, "_stable"}, stable_err, 0);
      if (got_terms.size() == nn + 1)
        for (int i = 0; i <= nn; i++)
          check({tag, "_term"}, got_terms[i], fib_true(i) & 64'hFFFF);
    end else begin
      check({tag, "_busy"}, run_busy, 2 * nn + 3);
      check({tag, "_nterms"}, got_terms.size(), 0);
    end
  endtask

  initial begin
    int          seen_done;
    int          nn;
    bit          md;
    logic [W-1:0] prior;

    vecs[0]  = '{0, 1'b0, 64'd0, 1'b0};
    vecs[1]  = '{1, 1'b0, 64'd1, 1'b0};
    vecs[2]  = '{2, 1'b0, 64'd1, 1'b0};
    vecs[3]  = '{3, 1'b0, 64'd2, 1'b0};
    vecs[4]  = '{10, 1'b0, 64'd55, 1'b0};
    vecs[5]  = '{24, 1'b0, 64'd46368, 1'b0};
    vecs[6]  = '{25, 1'b0, 64'd9489, 1'b1};
    vecs[7]  = '{23, 1'b0, 64'd28657, 1'b0};
    vecs[8]  = '{0, 1'b1, 64'd0, 1'b0};
    vecs[9]  = '{12, 1'b1, 64'd144, 1'b0};
    vecs[10] = '{10, 1'b0, 64'd55, 1'b0};

    bus.start      = 1'b0;
    bus.n          = '0;
    bus.mode       = 1'b0;
    bus.abort      = 1'b0;
    bus.term_ready = 1'b0;

    // Reset state.
    #12;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_result", bus.result, 0);
    check("rst_ovf", bus.overflow, 0);
    check("rst_tvalid", bus.term_valid, 0);
    check("rst_term", bus.term, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table.
    foreach (vecs[i]) begin
      do_run(vecs[i].n, vecs[i].mode, 0, 0);
      check("vec_result", bus.result, vecs[i].exp_res);
      check("vec_ovf", bus.overflow, vecs[i].exp_ovf);
      check_run("vec", vecs[i].n, vecs[i].mode);
      @(negedge clk);
      check("vec_done_width", bus.done, 0);
      check("vec_idle", bus.busy, 0);
      repeat (3) @(negedge clk);
      check("vec_hold", bus.result, vecs[i].exp_res);
    end

    // Streaming with a 1-0-0 ready pattern.
    do_run(5, 1'b1, 1, 0);
    check_run("stall5", 5, 1'b1);
    check("stall5_some_stalls", (run_stalls > 0) ? 1 : 0, 1);

    // START during a run is ignored.
    do_run(10, 1'b0, 0, 4);
    check_run("midstart", 10, 1'b0);
    prior = bus.result;

    // Abort at the 5th busy cycle, with an ignored START inside the run.
    @(negedge clk);
    bus.start = 1'b1;
    bus.n     = 6'd20;
    bus.mode  = 1'b0;
    @(posedge clk);
    seen_done = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      bus.start = (c == 2);
      bus.n     = 6'd3;
      if (bus.done) seen_done++;
      if (c == 5) bus.abort = 1'b1;
    end
    @(negedge clk);
    bus.abort = 1'b0;
    bus.start = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_result", bus.result, prior);
    repeat (4) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen_done++;
    end
    check("abort_no_done", seen_done, 0);

    // Abort and ready together in EMIT: abort wins.
    @(negedge clk);
    bus.start = 1'b1;
    bus.n     = 6'd5;
    bus.mode  = 1'b1;
    @(posedge clk);
    seen_done = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.term_valid) begin
        seen_done = 1;
        break;
      end
    end
    check("emit_reached", seen_done, 1);
    bus.term_ready = 1'b1;
    bus.abort      = 1'b1;
    @(negedge clk);
    bus.term_ready = 1'b0;
    bus.abort      = 1'b0;
    check("emit_abort_tvalid", bus.term_valid, 0);
    check("emit_abort_busy", bus.busy, 0);
    check("emit_abort_result", bus.result, prior);

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    bus.start = 1'b1;
    bus.n     = 6'd20;
    bus.mode  = 1'b0;
    @(posedge clk);
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_result", bus.result, 0);
    check("arst_ovf", bus.overflow, 0);
    check("arst_done", bus.done, 0);
    check("arst_tvalid", bus.term_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_run(3, 1'b0, 0, 0);
    check_run("after_rst", 3, 1'b0);

    // Randomized runs against the reference.
    for (int k = 0; k < 16; k++) begin
      nn = $urandom_range(0, 63);
      md = 1'($urandom_range(0, 1));
      do_run(nn, md, 2, 0);
      check_run("rand", nn, md);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fib_engine.md
Name: fib_engine

Overview:
- Parametrised successor to the Fibonacci controller FSM. It merges control and datapath into one block that computes F(N) for a run-time N at a configurable word width.
- Adds an optional streaming mode that emits every term F(0)..F(N) over a valid/ready handshake.
- Adds an abort input and a sticky overflow flag.
- Sits between the top-level START/DONE control and the result display/term-consumer logic.

Parameters:
- WIDTH, 16, bit width of terms, RESULT and TERM.
- N_WIDTH, 6, bit width of the requested index N (N max = 2^N_WIDTH-1).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset; asynchronous, active-low.
- START  in  1  request computation; sampled in IDLE only.
- N  in  N_WIDTH  requested index; latched when START is accepted.
- MODE  in  1  0 = result only, 1 = stream terms; latched with N.
- ABORT  in  1  cancel the current run; ignored in IDLE.
- TERM  out  WIDTH  streamed term value.
- TERM_VALID  out  1  TERM is valid.
- TERM_READY  in  1  consumer accepts TERM.
- RESULT  out  WIDTH  F(N) mod 2^WIDTH; held until the next accepted START.
- OVERFLOW  out  1  true F(N) exceeded 2^WIDTH-1; updated with RESULT.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse when RESULT/OVERFLOW are updated.

Behaviour:
- Reset (RST=0, async): state=IDLE; RESULT=0, OVERFLOW=0, TERM=0, TERM_VALID=0, BUSY=0, DONE=0; internal A, B, CNT, flags cleared. Reset mid-run discards all work.
- Internal registers: A, B (WIDTH); CNT (N_WIDTH); ovf_a, ovf_b; mode_q.
- States: IDLE, LOAD, CHECK, EMIT, ADD, FINISH. All outputs are registered or Moore.
- IDLE:
  - START=1 → latch N into CNT and MODE into mode_q; go to LOAD.
  - START=0 → stay in IDLE.
- LOAD: A=0, B=1, ovf_a=0, ovf_b=0; → CHECK.
- CHECK:
  - mode_q=1 → EMIT.
  - else CNT==0 → FINISH.
  - else → ADD.
- EMIT:
  - TERM=A, TERM_VALID=1, with TERM stable while TERM_READY=0.
  - On an edge with TERM_READY=1: TERM_VALID drops next cycle. If CNT==0 → FINISH, else → ADD.
- ADD:
  - {carry,sum} = A+B at WIDTH+1 bits; A←B; B←sum (truncated).
  - ovf_a←ovf_b; ovf_b←ovf_b|carry; CNT←CNT-1.
  - → CHECK.
- FINISH: RESULT←A, OVERFLOW←ovf_a, DONE=1 for exactly this one cycle; → IDLE.
- Latency, mode 0: DONE is high in cycle 2N+3, counting the START-sampling edge as edge 0 (3 + 2 per term).
- Latency, mode 1: as mode 0, plus one cycle per EMIT plus any stall cycles.
- Overflow tracking: a carry produced while computing F(N+1) (the last ADD) does not set OVERFLOW; only the validity of A matters.
- ABORT=1 in any non-IDLE state → IDLE on the next edge, with TERM_VALID=0. DONE is not pulsed; RESULT and OVERFLOW keep their previous values. ABORT has priority over all other transitions.
- START while BUSY is ignored. START held high continuously restarts a new run one cycle after FINISH (IDLE→LOAD).
- Simultaneous ABORT and TERM_READY in EMIT: ABORT wins and the term counts as not accepted.
- N=0: mode 0 goes directly CHECK→FINISH with RESULT=0; mode 1 emits the single term 0.

Test Plan:
- Reset, N=0, MODE=0, START pulse → DONE exactly 3 edges later, RESULT=0, OVERFLOW=0, BUSY high for 3 cycles.
- N=10, MODE=0 → DONE at edge 23, RESULT=55, DONE width exactly 1 cycle; RESULT held after START deasserts.
- WIDTH=16: N=24 → RESULT=46368, OVERFLOW=0. N=25 → RESULT=9489 (75025 mod 65536), OVERFLOW=1.
- N=5, MODE=1, TERM_READY toggled 1-0-0-1… → accepted terms exactly 0,1,1,2,3,5 with TERM stable while stalled; then RESULT=5, DONE pulse.
- N=20, ABORT at the 5th busy cycle → IDLE next edge, no DONE, RESULT keeps the prior run's value. START pressed during BUSY has no effect.
- RST low asynchronously mid-run (between edges) → all outputs 0 immediately. After release, N=3 → RESULT=2.
